// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter and the clock divider it mirrors:
// FSM state encoding, default counter width and the 50 MHz cycles-per-second
// constant used for divisor/period sizing.
package period_meter_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StMeasure = 2'd2
  } state_e;

  // 28 bits holds one second's worth of 50 MHz cycles.
  localparam int unsigned DefaultWidth    = 28;
  localparam int unsigned CyclesPerSecond = 50_000_000;

  // Bits needed to hold counts 0..max_count inclusive.
  function automatic int unsigned count_width(input int unsigned max_count);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((max_count >> w) != 0)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by one edge
// register. Rise/Fall are single-cycle pulses in the destination domain.
module period_meter_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_signal,
  output logic o_rise,
  output logic o_fall,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_level;

  // Shift the raw input through the synchronizer chain; remember last level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_level = w_level;
  assign o_rise  = w_level & ~r_edge;
  assign o_fall  = ~w_level & r_edge;

endmodule

// File: rtl/period_meter.sv
// Period meter: measures the spacing of rising edges of an asynchronous slow
// signal in i_clock_in cycles, strobes each completed period and flags loss of
// signal after TIMEOUT cycles without a rising edge.
// Optional build macro PERIOD_METER_HIGH_TIME_EN adds o_high_time, the number
// of cycles the signal was high within the reported period.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned TIMEOUT     = CyclesPerSecond,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clock_in,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_signal_in,
  output logic [WIDTH-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_timeout,
`ifdef PERIOD_METER_HIGH_TIME_EN
  output logic [WIDTH-1:0] o_high_time,
`endif
  output logic             o_measuring
);

  localparam logic [WIDTH-1:0] TimeoutCount = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CountOne     = WIDTH'(1);

  logic w_rise;
  logic w_fall;
  logic w_level;
  logic w_unused_level;

  state_e           r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_period;
  logic             r_period_valid;
  logic             r_timeout;
  logic             r_measuring;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] r_high_latch;
  logic [WIDTH-1:0] r_high_time;
`else
  logic             w_unused_fall;
  assign w_unused_fall = w_fall;
`endif

  // The synchronized level itself is not needed here, only its edges.
  assign w_unused_level = w_level;

  period_meter_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .i_clk    (i_clock_in),
    .i_rst    (i_reset),
    .i_signal (i_signal_in),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_level  (w_level)
  );

  // Measurement FSM with registered strobes; Enable low overrides every state.
  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_counter      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_measuring    <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      r_high_latch   <= '0;
      r_high_time    <= '0;
`endif
    end else begin
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
      if (!i_enable) begin
        r_state     <= StIdle;
        r_counter   <= '0;
        r_measuring <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_counter <= '0;
            r_state   <= StArmed;
          end
          StArmed: begin
            // The first rise only opens a period; nothing is reported yet.
            if (w_rise) begin
              r_counter   <= CountOne;
              r_state     <= StMeasure;
              r_measuring <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
              r_high_latch <= '0;
`endif
            end
          end
          StMeasure: begin
            // A rise on the timeout cycle still counts as a valid period.
            if (w_rise) begin
              r_period       <= r_counter;
              r_period_valid <= 1'b1;
              r_counter      <= CountOne;
`ifdef PERIOD_METER_HIGH_TIME_EN
              r_high_time    <= r_high_latch;
              r_high_latch   <= '0;
`endif
            end else if (r_counter == TimeoutCount) begin
              r_timeout   <= 1'b1;
              r_counter   <= '0;
              r_state     <= StArmed;
              r_measuring <= 1'b0;
            end else begin
              r_counter <= r_counter + CountOne;
`ifdef PERIOD_METER_HIGH_TIME_EN
              if (w_fall) begin
                r_high_latch <= r_counter;
              end
`endif
            end
          end
          default: begin
            r_state     <= StIdle;
            r_counter   <= '0;
            r_measuring <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_timeout      = r_timeout;
  assign o_measuring    = r_measuring;
`ifdef PERIOD_METER_HIGH_TIME_EN
  assign o_high_time    = r_high_time;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter. A timestamp-based model tracks when
// rising edges become visible after synchronization and derives the expected
// outputs; a compare process checks them every cycle, and directed phases add
// literal expectations for specific scenarios before a randomized phase.
module tb_period_meter;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 20;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         sig = 1'b0;
  logic [W-1:0] period;
  logic         valid;
  logic         tmo;
  logic         meas;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [W-1:0] high_time;
`endif

  period_meter #(
    .WIDTH       (W),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .i_clock_in     (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_signal_in    (sig),
    .o_period       (period),
    .o_period_valid (valid),
    .o_timeout      (tmo),
`ifdef PERIOD_METER_HIGH_TIME_EN
    .o_high_time    (high_time),
`endif
    .o_measuring    (meas)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MOff, MArmed, MMeas} mmode_e;
  mmode_e m_mode     = MOff;
  int     cyc        = 0;
  int     m_start    = 0;
  int     m_period   = 0;
  int     m_high     = 0;
  int     m_high_out = 0;
  bit     m_valid    = 1'b0;
  bit     m_to       = 1'b0;
  bit     hist [0:SS+1];

  initial begin
    for (int i = 0; i <= SS + 1; i++) hist[i] = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = MOff; m_start = 0; m_period = 0; m_high = 0; m_high_out = 0;
        m_valid = 1'b0; m_to = 1'b0;
        for (int i = 0; i <= SS + 1; i++) hist[i] = 1'b0;
      end else begin
        bit lvl, prv, rise, fall;
        cyc++;
        // Input seen by the FSM at this edge lags the pin by SS+1 cycles.
        for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig;
        lvl  = hist[SS];
        prv  = hist[SS+1];
        rise = lvl && !prv;
        fall = !lvl && prv;
        m_valid = 1'b0;
        m_to    = 1'b0;
        if (!en) begin
          m_mode = MOff;
        end else begin
          case (m_mode)
            MOff:   m_mode = MArmed;
            MArmed: if (rise) begin m_mode = MMeas; m_start = cyc; m_high = 0; end
            MMeas: begin
              if (rise) begin
                m_valid    = 1'b1;
                m_period   = cyc - m_start;
                m_high_out = m_high;
                m_high     = 0;
                m_start    = cyc;
              end else begin
                if (fall) m_high = cyc - m_start;
                if (cyc - m_start == int'(TO)) begin
                  m_to   = 1'b1;
                  m_mode = MArmed;
                end
              end
            end
            default: m_mode = MOff;
          endcase
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int n_valid = 0;
  int n_to    = 0;
  int last_valid_cyc = 0;
  int last_to_cyc    = 0;
  bit prev_strobe    = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
      end else begin
        check("period", int'(period), m_period);
        check("period_valid", int'(valid), int'(m_valid));
        check("timeout", int'(tmo), int'(m_to));
        check("measuring", int'(meas), int'(m_mode == MMeas));
`ifdef PERIOD_METER_HIGH_TIME_EN
        check("high_time", int'(high_time), m_high_out);
`endif
        check("strobe_exclusive", int'(valid && tmo), 0);
        check("strobe_consecutive", int'(prev_strobe && (valid || tmo)), 0);
        prev_strobe = valid || tmo;
        if (valid) begin n_valid++; last_valid_cyc = cyc; end
        if (tmo)   begin n_to++;    last_to_cyc    = cyc; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input bit e);
    @(posedge clk);
    #1;
    sig = s;
    en  = e;
  endtask

  task automatic wave(input int p, input int h, input int n, input bit e);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < p; c++) drive(c < h, e);
  endtask

  task automatic hold_low(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1);
  endtask

  // Force IDLE then re-arm, and clear the strobe tallies.
  task automatic quiesce();
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1);
    n_valid = 0;
    n_to    = 0;
  endtask

  initial begin
    int v_before, v_mid;
    repeat (3) @(posedge clk);
    #1;
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(tmo), 0);
    check("reset_measuring", int'(meas), 0);
    rst = 1'b0;

    // Divide-by-4 clock: steady Period=4, no timeouts.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1);
    n_valid = 0; n_to = 0;
    wave(4, 2, 10, 1'b1);
    hold_low(6);
    check("div4_strobes", n_valid, 9);
    check("div4_timeouts", n_to, 0);
    check("div4_period", int'(period), 4);

    // 10-cycle wave then silence: timeout 20 cycles after last report.
    quiesce();
    wave(10, 5, 5, 1'b1);
    hold_low(30);
    check("loss_strobes", n_valid, 4);
    check("loss_timeouts", n_to, 1);
    check("loss_timeout_gap", last_to_cyc - last_valid_cyc, int'(TO));
    check("loss_period_held", int'(period), 10);
    check("loss_rearmed", int'(meas), 0);

    // Rises exactly TIMEOUT apart: rise wins.
    quiesce();
    wave(20, 3, 4, 1'b1);
    check("edge_to_strobes", n_valid, 3);
    check("edge_to_timeouts", n_to, 0);
    check("edge_to_period", int'(period), 20);

    // Enable dropped 5 cycles into a period, restored mid low phase.
    quiesce();
    v_before = 0; v_mid = 0;
    for (int c = 0; c < 16 * 7; c++) begin
      if (c == 37) v_before = n_valid;
      if (c == 74) v_mid = n_valid;
      drive((c % 16) < 8, !(c >= 37 && c < 74));
    end
    check("en_before_drop", v_before, 2);
    check("en_while_off", v_mid - v_before, 0);
    check("en_after_rearm", n_valid - v_mid, 1);
    check("en_period", int'(period), 16);

    // Asynchronous reset mid-measurement.
    quiesce();
    wave(12, 6, 2, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_period", int'(period), 0);
    check("rst_mid_valid", int'(valid), 0);
    check("rst_mid_timeout", int'(tmo), 0);
    check("rst_mid_measuring", int'(meas), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    n_valid = 0; n_to = 0;
    wave(12, 6, 3, 1'b1);
    hold_low(4);
    check("rst_resume_strobes", n_valid, 2);
    check("rst_resume_period", int'(period), 12);

    // Fastest legal signal: Period=2.
    quiesce();
    wave(2, 1, 8, 1'b1);
    hold_low(4);
    check("min_strobes", n_valid, 7);
    check("min_period", int'(period), 2);

`ifdef PERIOD_METER_HIGH_TIME_EN
    quiesce();
    wave(18, 5, 3, 1'b1);
    hold_low(4);
    check("duty_period", int'(period), 18);
    check("duty_high", int'(high_time), 5);
`endif

    // Randomized waves, gaps and enable drops against the model.
    quiesce();
    for (int r = 0; r < 40; r++) begin
      int p, h, n;
      bit e;
      p = int'($urandom_range(2, 26));
      h = int'($urandom_range(1, p - 1));
      n = int'($urandom_range(1, 3));
      e = ($urandom_range(0, 7) != 0);
      wave(p, h, n, e);
      if ($urandom_range(0, 5) == 0) hold_low(int'($urandom_range(15, 30)));
    end
    hold_low(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
